// File: rtl/rvs192_writeback_arbiter_pkg.sv
// rvs192_writeback_arbiter_pkg: shared entry type and write-port source encoding
package rvs192_writeback_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {WB_IDLE, WB_ALU, WB_MEM} wb_src_e;
endpackage

// File: rtl/rvs192_writeback_arbiter_if.sv
// rvs192_writeback_arbiter_if: ALU, memory-response, issue and register-file write signals
interface rvs192_writeback_arbiter_if #(
    parameter int DATA_LENGTH         = 32,
    parameter int REGISTER_FILE_DEPTH = 32
);
    logic                           alu_valid;
    logic [4:0]                     alu_rd;
    logic [DATA_LENGTH-1:0]         alu_data;
    logic                           alu_stall;
    logic                           mem_valid;
    logic                           mem_ready;
    logic [4:0]                     mem_rd;
    logic [DATA_LENGTH-1:0]         mem_data;
    logic                           issue_valid;
    logic [4:0]                     issue_rd;
    logic [REGISTER_FILE_DEPTH-1:0] pending_mask;
    logic [DATA_LENGTH-1:0]         data_wb;
    logic [4:0]                     rd;
    logic                           reg_wen;

    modport master (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
        output alu_stall, mem_ready, pending_mask, data_wb, rd, reg_wen
    );
    modport slave (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
        input  alu_stall, mem_ready, pending_mask, data_wb, rd, reg_wen
    );
endinterface

// File: rtl/rvs192_wb_fifo.sv
// rvs192_wb_fifo: synchronous circular FIFO with wrap-bit pointers
module rvs192_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic             do_push, do_pop;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = wr_q + (AW+1)'(do_push);
    assign rd_d    = rd_q + (AW+1)'(do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/rvs192_writeback_arbiter.sv
// rvs192_writeback_arbiter: merges ALU and buffered load results onto the register-file write port
module rvs192_writeback_arbiter
    import rvs192_writeback_arbiter_pkg::*;
#(
    parameter int DATA_LENGTH         = DATA_W,
    parameter int REGISTER_FILE_DEPTH = 32,
    parameter int MEM_FIFO_DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rvs192_writeback_arbiter_if.master  bus
);
    wb_entry_t                      alu_in, mem_in, head, sel;
    wb_src_e                        src;
    logic                           full, empty, push, pop;
    logic                           wen_q, wen_d;
    logic [4:0]                     rd_q, rd_d;
    logic [DATA_LENGTH-1:0]         data_q, data_d;
    logic [REGISTER_FILE_DEPTH-1:0] mask_q, mask_d;

    assign alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
    assign mem_in = '{rd: bus.mem_rd, data: bus.mem_data};
    // a full FIFO outranks the ALU so loads can never be starved into deadlock
    assign src    = full ? WB_MEM : bus.alu_valid ? WB_ALU : !empty ? WB_MEM : WB_IDLE;
    assign push   = bus.mem_valid && !full;
    assign pop    = src == WB_MEM;
    assign sel    = (src == WB_ALU) ? alu_in : head;

    rvs192_wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(MEM_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (mem_in),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign wen_d  = (src != WB_IDLE) && (sel.rd != '0);
    assign rd_d   = (src != WB_IDLE) ? sel.rd : rd_q;
    assign data_d = (src != WB_IDLE) ? sel.data : data_q;

    always_comb begin
        mask_d = mask_q;
        if (pop && head.rd != '0) mask_d[head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) mask_d[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign bus.alu_stall    = bus.alu_valid && full;
    assign bus.mem_ready    = !full;
    assign bus.pending_mask = mask_q;
    assign bus.data_wb      = data_q;
    assign bus.rd           = rd_q;
    assign bus.reg_wen      = wen_q;
endmodule

// File: doc/rvs192_writeback_arbiter.md
Name: rvs192_writeback_arbiter

Overview:
- Write-side master for the RVS192 register file: drives data_wb, rd and reg_wen into the register file's single write port.
- Merges two result sources: a single-cycle ALU path and a variable-latency memory/load response path with a valid/ready handshake.
- Buffers memory responses in a small FIFO.
- Keeps a per-register pending scoreboard that the hazard unit reads to stall consumers of outstanding loads.

Parameters:
DATA_LENGTH, 32, width of register data (from RVS192_user_parameters)
REGISTER_FILE_DEPTH, 32, number of architectural registers
MEM_FIFO_DEPTH, 2, memory-response buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  DATA_LENGTH  ALU result
alu_stall  out  1  ALU result not accepted; source holds alu_* unchanged
mem_valid  in  1  memory response present
mem_ready  out  1  arbiter can accept memory response
mem_rd  in  5  load destination register
mem_data  in  DATA_LENGTH  load data
issue_valid  in  1  load issued to memory this cycle
issue_rd  in  5  destination of issued load
pending_mask  out  REGISTER_FILE_DEPTH  bit i = load to register i outstanding
data_wb  out  DATA_LENGTH  register file write data
rd  out  5  register file write address
reg_wen  out  1  register file write enable

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset: data_wb=0, rd=0, reg_wen=0, FIFO empty, pending_mask=0, alu_stall=0 (combinational, follows the empty FIFO), mem_ready=1.
- Memory acceptance: mem_valid & mem_ready pushes {mem_rd, mem_data} into the FIFO. mem_ready = !full, computed from registered state only; a pop in the same cycle does not raise it.
- Arbitration, evaluated each cycle, first match wins:
  (1) FIFO full and not empty: pop FIFO head to the write port; alu_stall = alu_valid.
  (2) alu_valid: ALU owns the write port; alu_stall = 0.
  (3) FIFO not empty: pop FIFO head.
  (4) Otherwise: idle.
- The ALU therefore wins unless the FIFO is full, which prevents ALU starvation-induced memory deadlock.
- Write-port outputs are registered, one-cycle latency: the selected {rd, data} appears on rd/data_wb with reg_wen=1 in the cycle after acceptance/pop. When idle, reg_wen=0, and rd/data_wb hold their last values.
- x0 suppression: a selected entry with rd=0 is consumed (popped or accepted) but drives reg_wen=0.
- FIFO: circular with wrap-around pointers; push and pop in the same cycle are both legal, including when full (pop frees the slot, but mem_ready was already 0, so no push occurs). Pushed data is not bypassed to the write port in its push cycle.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending_mask[issue_rd] at the next edge.
  - The bit clears on the edge where that memory entry is driven with reg_wen=1.
  - Same-cycle set and clear on the same register: set wins.
  - Issuing to an already-pending register is illegal (the hazard unit prevents it); the bench asserts on it.
- pending_mask is registered, so it is visible the cycle after issue.
- Reset mid-operation: FIFO contents are discarded, the scoreboard is cleared, and no write is emitted in the reset cycle or the first cycle after.

Decomposition:
- RVS192_package: wb_entry_t struct {logic [4:0] rd; logic [DATA_LENGTH-1:0] data;} and the wb_src_e enum {WB_IDLE, WB_ALU, WB_MEM}.
- Sub-module rvs192_wb_fifo (parameterised sync FIFO with push, pop, full, empty, head).
- The top level holds the arbiter, output register and scoreboard.

Test Plan:
- ALU only: alu_valid, rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1: reg_wen=1, rd=5, data_wb=0xDEADBEEF; alu_stall=0 throughout.
- Memory only: issue rd=7; 3 cycles later mem_valid, data=0x12345678 -> pending_mask[7]=1 from issue+1; write appears 2 cycles after acceptance (push, then pop/register), pending_mask[7]=0 on that edge.
- Contention: continuous alu_valid with two mem responses (rd=3, rd=4) -> FIFO fills, mem_ready=0; next cycle alu_stall=1, rd=3 is written, then ALU resumes and rd=4 drains when the ALU is idle; no data is lost and order is preserved.
- x0: alu_rd=0 and mem_rd=0 entries -> reg_wen never asserted; FIFO still drains; pending_mask[0] stays 0.
- Simultaneous set/clear: mem writeback of rd=9 in the same cycle as issue_rd=9 (after the prior load's clear) -> pending_mask[9] remains 1.
- Reset mid-operation: FIFO holding 2 entries and pending bits set, assert rst_n=0 for 1 cycle -> mask=0, mem_ready=1, no reg_wen for the two following cycles.
